// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter family.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_ABORT
    } arb_state_t;

    localparam int unsigned MAX_MASTERS = 16;
    localparam int unsigned MAX_IDX_W   = 4;

    // Grant index width: at least one bit even for a single master.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester scanning last+1, last+2, ... modulo n; returns last if none.
    function automatic logic [MAX_IDX_W-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [MAX_IDX_W-1:0]   last,
        input int unsigned            n
    );
        logic [MAX_IDX_W-1:0] pick;
        logic                 found;
        int unsigned          idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
            idx = (32'(last) + i) % n;
            if (!found && (i <= n) && req[MAX_IDX_W'(idx)]) begin
                pick  = MAX_IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_rr_arb_pick.sv
// Combinational round-robin priority selector.
module wb_rr_arb_pick
    import wb_arb_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS = 3,
    localparam int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_last,
    output logic [IDX_W-1:0]       o_pick,
    output logic                   o_valid
);

    logic [MAX_MASTERS-1:0] w_req;
    logic [MAX_IDX_W-1:0]   w_last;

    // Widen to the package function's fixed operand sizes.
    assign w_req   = MAX_MASTERS'(i_req);
    assign w_last  = MAX_IDX_W'(i_last);
    assign o_pick  = IDX_W'(rr_pick(w_req, w_last, NUM_MASTERS));
    assign o_valid = |i_req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone multi-master arbiter with per-transfer ack watchdog.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 3,
    parameter int unsigned ADDR_WIDTH     = 2,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_MASTERS-1:0]           m_cyc_i,
    input  logic [NUM_MASTERS-1:0]           m_stb_i,
    input  logic [NUM_MASTERS-1:0]           m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]           m_ack_o,
    output logic [NUM_MASTERS-1:0]           m_err_o,
    output logic [DATA_WIDTH-1:0]            m_dat_o,
    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [ADDR_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    input  logic                             s_ack_i,
    input  logic [DATA_WIDTH-1:0]            s_dat_i,
    output logic [NUM_MASTERS-1:0]           gnt_o
);

    localparam int unsigned     IDX_W     = idx_width(NUM_MASTERS);
    localparam int unsigned     WD_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit              WD_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_MASTERS - 1);

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_last;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic [WD_W-1:0]        r_wd;

    logic [IDX_W-1:0]       w_pick;
    logic                   w_pick_valid;
    logic                   w_grant;
    logic                   w_own_cyc;
    logic                   w_expire;
    logic [ADDR_WIDTH-1:0]  w_adr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  w_dat [NUM_MASTERS];

    wb_rr_arb_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .i_req   (m_cyc_i),
        .i_last  (r_last),
        .o_pick  (w_pick),
        .o_valid (w_pick_valid)
    );

    // Split the flattened master buses into per-master lanes.
    always_comb begin
        for (int k = 0; k < int'(NUM_MASTERS); k++) begin
            w_adr[k] = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            w_dat[k] = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Owner's bus reaches the slave only while granted; ack/err steered to the owner.
    assign w_grant   = (r_state == ARB_GRANT);
    assign w_own_cyc = m_cyc_i[r_owner];
    assign s_cyc_o   = w_grant & w_own_cyc;
    assign s_stb_o   = s_cyc_o & m_stb_i[r_owner];
    assign s_we_o    = s_cyc_o & m_we_i[r_owner];
    assign s_adr_o   = s_cyc_o ? w_adr[r_owner] : '0;
    assign s_dat_o   = s_cyc_o ? w_dat[r_owner] : '0;
    assign m_dat_o   = w_grant ? s_dat_i : '0;
    assign w_expire  = WD_EN && s_stb_o && !s_ack_i && (r_wd == WD_LAST);
    assign m_ack_o   = w_grant ? (r_gnt & {NUM_MASTERS{s_ack_i}}) : '0;
    assign m_err_o   = r_gnt & {NUM_MASTERS{w_expire}};
    assign gnt_o     = r_gnt;

    // Arbitration FSM: grant held for the owner's whole cyc tenure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
            r_last  <= LAST_INIT;
            r_gnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= ARB_GRANT;
                        r_owner <= w_pick;
                        r_last  <= w_pick;
                        r_gnt   <= NUM_MASTERS'(1) << w_pick;
                    end
                end
                ARB_GRANT: begin
                    if (!w_own_cyc) begin
                        r_state <= ARB_IDLE;
                        r_gnt   <= '0;
                    end else if (w_expire) begin
                        r_state <= ARB_ABORT;
                    end
                end
                ARB_ABORT: begin
                    if (!w_own_cyc) begin
                        r_state <= ARB_IDLE;
                        r_gnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    // Ack watchdog: counts unacked strobe cycles, clears on ack, idle strobe or expiry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wd <= '0;
        end else if (s_stb_o && !s_ack_i && !w_expire) begin
            r_wd <= r_wd + WD_W'(1);
        end else begin
            r_wd <= '0;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (3 masters, 16-cycle watchdog).
module tb_wb_rr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [5:0]  m_adr_i;
    logic [23:0] m_dat_i;
    logic [2:0]  m_ack_o, m_err_o, gnt_o;
    logic [7:0]  m_dat_o, s_dat_o, s_dat_i;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [1:0]  s_adr_o;

    int n_pass  = 0;
    int n_total = 0;

    wb_rr_arbiter #(
        .NUM_MASTERS    (3),
        .ADDR_WIDTH     (2),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i),
        .gnt_o   (gnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0;
        s_ack_i = 1'b0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle_all();
        tick(); tick();
        rst_i = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_gnt",  32'(gnt_o),   32'h0);
        chk("rst_scyc", 32'(s_cyc_o), 32'h0);
        chk("rst_sstb", 32'(s_stb_o), 32'h0);
        chk("rst_ack",  32'(m_ack_o), 32'h0);
        chk("rst_err",  32'(m_err_o), 32'h0);
        chk("rst_mdat", 32'(m_dat_o), 32'h0);

        // Single master 1 write adr=2 dat=0xA5
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_we_i[1] = 1'b1;
        m_adr_i[3:2] = 2'd2; m_dat_i[15:8] = 8'hA5;
        #1;
        chk("t1_scyc_idle", 32'(s_cyc_o), 32'h0);
        tick(); #1;
        chk("t1_scyc", 32'(s_cyc_o), 32'h1);
        chk("t1_swe",  32'(s_we_o),  32'h1);
        chk("t1_sadr", 32'(s_adr_o), 32'h2);
        chk("t1_sdat", 32'(s_dat_o), 32'hA5);
        chk("t1_gnt",  32'(gnt_o),   32'h2);
        s_ack_i = 1'b1; s_dat_i = 8'h3C;
        #1;
        chk("t1_ack",  32'(m_ack_o), 32'h2);
        chk("t1_mdat", 32'(m_dat_o), 32'h3C);
        tick();
        idle_all();
        #1;
        chk("t1_scyc_drop", 32'(s_cyc_o), 32'h0);
        tick(); #1;
        chk("t1_gnt_idle", 32'(gnt_o), 32'h0);

        // All three request together after reset: grants 0,1,2 with an IDLE gap
        do_reset();
        m_cyc_i = 3'b111; m_stb_i = 3'b111;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk("t2_gnt",  32'(gnt_o),   32'(1 << k));
            chk("t2_scyc", 32'(s_cyc_o), 32'h1);
            s_ack_i = 1'b1;
            #1;
            chk("t2_ack", 32'(m_ack_o), 32'(1 << k));
            tick();
            m_cyc_i[k] = 1'b0; m_stb_i[k] = 1'b0; s_ack_i = 1'b0;
            tick(); #1;
            chk("t2_idle_gnt",  32'(gnt_o),   32'h0);
            chk("t2_idle_scyc", 32'(s_cyc_o), 32'h0);
        end

        // Master 0 holds cyc across 4 transfers while master 2 waits
        m_cyc_i = 3'b101; m_stb_i = 3'b101;
        tick();
        for (int i = 0; i < 4; i++) begin
            m_adr_i[1:0] = 2'(i); s_ack_i = 1'b1;
            #1;
            chk("t3_ack",  32'(m_ack_o), 32'h1);
            chk("t3_sadr", 32'(s_adr_o), 32'(i));
            tick();
            s_ack_i = 1'b0;
            #1;
            chk("t3_gnt_hold", 32'(gnt_o), 32'h1);
            tick();
        end
        m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
        #1;
        chk("t3_gnt_last", 32'(gnt_o), 32'h1);
        tick(); #1;
        chk("t3_idle", 32'(gnt_o), 32'h0);
        tick(); #1;
        chk("t3_gnt2", 32'(gnt_o), 32'h4);
        s_ack_i = 1'b1;
        tick();
        idle_all();
        tick();

        // Watchdog: slave never acks master 1
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            #1;
            chk("t4_err", 32'(m_err_o), (c == 16) ? 32'h2 : 32'h0);
            tick();
        end
        #1;
        chk("t4_abort_scyc", 32'(s_cyc_o), 32'h0);
        chk("t4_abort_sstb", 32'(s_stb_o), 32'h0);
        chk("t4_abort_err",  32'(m_err_o), 32'h0);
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; s_ack_i = 1'b1;
        #1;
        chk("t4_spurious_ack", 32'(m_ack_o), 32'h0);
        tick(); tick(); #1;
        chk("t4_abort_gnt",  32'(gnt_o),   32'h2);
        chk("t4_abort_hold", 32'(s_cyc_o), 32'h0);
        s_ack_i = 1'b0;
        m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
        tick(); #1;
        chk("t4_idle", 32'(gnt_o), 32'h0);
        tick(); #1;
        chk("t4_next_gnt", 32'(gnt_o), 32'h1);

        // Ack on exactly the 16th strobe cycle wins over expiry
        for (int c = 1; c < 16; c++) begin
            #1;
            chk("t5_err_pre", 32'(m_err_o), 32'h0);
            tick();
        end
        s_ack_i = 1'b1;
        #1;
        chk("t5_ack", 32'(m_ack_o), 32'h1);
        chk("t5_err", 32'(m_err_o), 32'h0);
        tick();
        s_ack_i = 1'b0;
        #1;
        chk("t5_still_gnt", 32'(gnt_o),   32'h1);
        chk("t5_still_cyc", 32'(s_cyc_o), 32'h1);
        idle_all();
        tick(); tick();

        // Reset during master 1's pending read
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
        tick(); #1;
        chk("t6_gnt", 32'(gnt_o),  32'h2);
        chk("t6_swe", 32'(s_we_o), 32'h0);
        rst_i = 1'b1; s_ack_i = 1'b1; s_dat_i = 8'h5A;
        tick(); #1;
        chk("t6_rst_scyc", 32'(s_cyc_o), 32'h0);
        chk("t6_rst_sstb", 32'(s_stb_o), 32'h0);
        chk("t6_rst_gnt",  32'(gnt_o),   32'h0);
        chk("t6_rst_ack",  32'(m_ack_o), 32'h0);
        chk("t6_rst_mdat", 32'(m_dat_o), 32'h0);
        rst_i = 1'b0; s_ack_i = 1'b0;
        m_cyc_i = 3'b011; m_stb_i = 3'b011;
        tick(); #1;
        chk("t6_tie_gnt", 32'(gnt_o), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
